// File: rtl/tdm_slot_scheduler.sv
// Time-slot scheduler: one shared resource, N requesters, round-robin pointer
// modulo N with a per-slot cycle counter and early release.
module tdm_slot_scheduler #(
  parameter int N      = 5,
  parameter int SLOT_W = 8,
  parameter int PTR_W  = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [SLOT_W-1:0] slot_len_i,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      done_i,
  output logic [N-1:0]      gnt_o,
  output logic              gnt_vld_o,
  output logic [PTR_W-1:0]  gnt_id_o,
  output logic [SLOT_W-1:0] slot_cnt_o,
  output logic              wrap_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N - 1);
  localparam logic [PTR_W:0]   N_EXT   = (PTR_W + 1)'(N);

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [N-1:0]        gnt_q;
  logic                gnt_vld_q;
  logic [PTR_W-1:0]    gnt_id_q;
  logic [SLOT_W-1:0]   slot_cnt_q;
  logic [SLOT_W-1:0]   len_q;
  logic                wrap_q;

  logic [SLOT_W-1:0]   len_d;
  logic                cur_req;
  logic                cur_done;
  logic                slot_end;
  logic [PTR_W-1:0]    ptr_d;
  logic [PTR_W-1:0]    scan_ptr;
  logic [N-1:0]        scan_req;
  logic [PTR_W:0]      scan_idx;
  logic                sel_found;
  logic [PTR_W-1:0]    sel_id;

  assign len_d    = (slot_len_i == '0) ? SLOT_W'(1) : slot_len_i;
  assign cur_req  = req_i[gnt_id_q];
  assign cur_done = done_i[gnt_id_q];
  assign slot_end = (state_q == GRANT) &&
                    ((slot_cnt_q == len_q - SLOT_W'(1)) || cur_done || !cur_req);
  // Explicit compare so non-power-of-2 N wraps correctly.
  assign ptr_d    = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + PTR_W'(1);
  assign scan_ptr = (state_q == GRANT) ? ptr_d : ptr_q;
  // A requester that released early sits out the re-arbitration in its end cycle.
  assign scan_req = ((state_q == GRANT) && cur_done) ? (req_i & ~(N'(1) << gnt_id_q)) : req_i;

  // Descending loop so the candidate closest to scan_ptr is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = {1'b0, scan_ptr} + (PTR_W + 1)'(k);
      if (scan_idx >= N_EXT) begin
        scan_idx = scan_idx - N_EXT;
      end
      if (scan_req[scan_idx[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_id_q   <= '0;
      slot_cnt_q <= '0;
      len_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (en_i) begin
        case (state_q)
          IDLE: begin
            if (sel_found) begin
              state_q    <= GRANT;
              gnt_q      <= N'(1) << sel_id;
              gnt_vld_q  <= 1'b1;
              gnt_id_q   <= sel_id;
              slot_cnt_q <= '0;
              len_q      <= len_d;
            end
          end
          GRANT: begin
            if (slot_end) begin
              ptr_q  <= ptr_d;
              wrap_q <= (gnt_id_q == LAST_ID);
              if (sel_found) begin
                gnt_q      <= N'(1) << sel_id;
                gnt_id_q   <= sel_id;
                slot_cnt_q <= '0;
                len_q      <= len_d;
              end else begin
                state_q    <= IDLE;
                gnt_q      <= '0;
                gnt_vld_q  <= 1'b0;
                gnt_id_q   <= '0;
                slot_cnt_q <= '0;
              end
            end else begin
              slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_vld_o  = gnt_vld_q;
  assign gnt_id_o   = gnt_id_q;
  assign slot_cnt_o = slot_cnt_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Bench for tdm_slot_scheduler: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_tdm_slot_scheduler;

  localparam int N      = 5;
  localparam int SLOT_W = 8;
  localparam int PTR_W  = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [SLOT_W-1:0] slot_len = '0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      done = '0;
  logic [N-1:0]      gnt_o;
  logic              gnt_vld_o;
  logic [PTR_W-1:0]  gnt_id_o;
  logic [SLOT_W-1:0] slot_cnt_o;
  logic              wrap_o;

  int checks = 0;
  int errors = 0;

  // Model: who owns the resource (-1 = nobody), pointer, slot progress.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_len   = 0;
  bit m_wrap  = 1'b0;

  tdm_slot_scheduler #(.N(N), .SLOT_W(SLOT_W)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .slot_len_i(slot_len),
    .req_i(req), .done_i(done), .gnt_o(gnt_o), .gnt_vld_o(gnt_vld_o),
    .gnt_id_o(gnt_id_o), .slot_cnt_o(slot_cnt_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int from, input logic [N-1:0] cands);
    for (int k = 0; k < N; k++) begin
      if (cands[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_len = 0; m_wrap = 1'b0;
  endfunction

  function automatic void start_slot(input int who);
    m_owner = who;
    m_cnt   = 0;
    m_len   = (slot_len == 0) ? 1 : int'(slot_len);
  endfunction

  // One rising edge worth of scheduling rules, applied to the current inputs.
  function automatic void model_step();
    logic [N-1:0] cands;
    int s;
    if (rst) begin
      model_reset();
      return;
    end
    m_wrap = 1'b0;
    if (!en) return;
    if (m_owner < 0) begin
      s = pick(m_ptr, req);
      if (s >= 0) start_slot(s);
    end else if (m_cnt == m_len - 1 || done[m_owner] || !req[m_owner]) begin
      m_wrap = (m_owner == N - 1);
      m_ptr  = (m_owner + 1) % N;
      cands  = req;
      if (done[m_owner]) cands[m_owner] = 1'b0;
      s = pick(m_ptr, cands);
      if (s >= 0) start_slot(s);
      else begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    return {g, m_owner >= 0, (m_owner >= 0) ? PTR_W'(m_owner) : PTR_W'(0),
            SLOT_W'(m_cnt), m_wrap};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {gnt_o, gnt_vld_o, gnt_vld_o ? gnt_id_o : PTR_W'(0), slot_cnt_o, wrap_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req = '0; done = '0; slot_len = 8'd1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_vec() !== 18'd0) begin
      errors++;
      $display("FAIL reset_idle got %h want 0", obs_vec());
    end
    req = 5'b01000; slot_len = 8'd6;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (gnt_o !== '0 || gnt_vld_o !== 1'b0 || slot_cnt_o !== '0 || wrap_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_grant got gnt=%b vld=%b cnt=%0d wrap=%b want all 0",
               gnt_o, gnt_vld_o, slot_cnt_o, wrap_o);
    end
    tick();
    rst = 1'b0; req = 5'b11111; slot_len = 8'd1;
    tick();
    checks++;
    if (gnt_id_o !== 3'd0 || gnt_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ptr_zero got id=%0d vld=%b want id=0 vld=1", gnt_id_o, gnt_vld_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00100; slot_len = 8'd3;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      checks++;
      if (gnt_o !== 5'b00100 || slot_cnt_o !== SLOT_W'(c % 3)) begin
        errors++;
        $display("FAIL single_direct cyc=%0d got gnt=%b cnt=%0d want gnt=00100 cnt=%0d",
                 c, gnt_o, slot_cnt_o, c % 3);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 5'b11111; slot_len = 8'd1;
    for (int c = 0; c < 11; c++) begin
      tick();
      checks++;
      if (gnt_id_o !== PTR_W'(c % N) || wrap_o !== (c == 5 || c == 10)) begin
        errors++;
        $display("FAIL round_robin cyc=%0d got id=%0d wrap=%b want id=%0d wrap=%b",
                 c, gnt_id_o, wrap_o, c % N, (c == 5 || c == 10));
      end
    end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req = 5'b00001; slot_len = 8'd1;
    tick();
    req = 5'b00000;
    tick();
    req = 5'b10001; slot_len = 8'd4;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ptr_wrap cyc=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 0 || c == 4) begin
        checks++;
        if (gnt_o !== ((c == 0) ? 5'b10000 : 5'b00001) || wrap_o !== (c == 4)) begin
          errors++;
          $display("FAIL ptr_wrap_direct cyc=%0d got gnt=%b wrap=%b", c, gnt_o, wrap_o);
        end
      end
    end
  endtask

  task automatic test_done_and_zero_len();
    do_reset();
    req = 5'b00110; slot_len = 8'd8;
    tick(); tick(); tick();
    done = 5'b00010;
    tick();
    done = '0;
    checks++;
    if (gnt_o !== 5'b00100 || slot_cnt_o !== '0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL done_release got gnt=%b cnt=%0d want gnt=00100 cnt=0", gnt_o, slot_cnt_o);
    end
    do_reset();
    req = 5'b00111; slot_len = 8'd0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (gnt_id_o !== PTR_W'(c % 3) || slot_cnt_o !== '0 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL zero_len cyc=%0d got id=%0d cnt=%0d want id=%0d cnt=0",
                 c, gnt_id_o, slot_cnt_o, c % 3);
      end
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    req = 5'b00001; slot_len = 8'd4;
    tick(); tick();
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      done = (c == 2) ? 5'b00001 : '0;
      slot_len = 8'(c);
      tick();
      checks++;
      if (gnt_o !== 5'b00001 || slot_cnt_o !== 8'd1) begin
        errors++;
        $display("FAIL freeze cyc=%0d got gnt=%b cnt=%0d want gnt=00001 cnt=1",
                 c, gnt_o, slot_cnt_o);
      end
    end
    done = '0; en = 1'b1; slot_len = 8'd4;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL freeze_resume cyc=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      en       = ($urandom % 8) != 0;
      slot_len = 8'($urandom % 6);
      if (($urandom % 4) == 0) req = N'($urandom);
      done     = (($urandom % 5) == 0) ? (N'(1) << ($urandom % N)) : '0;
      rst      = (($urandom % 150) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_done_and_zero_len();
    test_enable_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
